// File: rtl/binary_pulse_encoder.sv
// binary_pulse_encoder: walks a mirror of a downstream pulse-driven up/down
// counter toward a requested target by emitting one-cycle inc/dec pulses,
// optionally spaced by GAP idle cycles, then flags completion with done.
module binary_pulse_encoder #(
  parameter int WIDTH = 3,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic             inc,
  output logic             dec,
  output logic [WIDTH-1:0] mirror,
  output logic             busy,
  output logic             done
);

  // Gap counter needs to hold GAP; keep at least one bit so GAP=0 still elaborates.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt_reg, tgt_n;
  logic [WIDTH-1:0] mirror_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             inc_n, dec_n, done_n;

  // Ready only while idle and not being reset, so an accept can never race reset.
  assign target_ready = (state == IDLE) && !rst;
  assign busy         = (state == RUN);

  // State register; reset discards any latched target and in-flight pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt_reg <= '0;
      mirror  <= '0;
      gap_cnt <= '0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      tgt_reg <= tgt_n;
      mirror  <= mirror_n;
      gap_cnt <= gap_n;
      inc     <= inc_n;
      dec     <= dec_n;
      done    <= done_n;
    end
  end

  // Next-state: latch target on accept, then one step per non-gap cycle.
  always_comb begin
    state_n  = state;
    tgt_n    = tgt_reg;
    mirror_n = mirror;
    gap_n    = gap_cnt;
    inc_n    = 1'b0;
    dec_n    = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (target_valid) begin
          tgt_n   = target;
          state_n = RUN;
        end
      end
      RUN: begin
        if (gap_cnt != '0) begin
          gap_n = gap_cnt - 1'b1;
        end else if (mirror < tgt_reg) begin
          inc_n    = 1'b1;
          mirror_n = mirror + 1'b1;
          gap_n    = GW'(GAP);
        end else if (mirror > tgt_reg) begin
          dec_n    = 1'b1;
          mirror_n = mirror - 1'b1;
          gap_n    = GW'(GAP);
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_binary_pulse_encoder.sv
// Bench for binary_pulse_encoder: a GAP=0 and a GAP=2 instance, each feeding a
// small model of the downstream pulse counter. Expected per-edge outputs are
// queued when a target is driven and compared as the DUT produces them.
module tb_binary_pulse_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] t0 = '0, t2 = '0;
  logic       tv0 = 1'b0, tv2 = 1'b0;
  logic       rdy0, inc0, dec0, busy0, done0;
  logic       rdy2, inc2, dec2, busy2, done2;
  logic [2:0] mir0, mir2;

  binary_pulse_encoder #(.WIDTH(3), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .target(t0), .target_valid(tv0), .target_ready(rdy0),
    .inc(inc0), .dec(dec0), .mirror(mir0), .busy(busy0), .done(done0));

  binary_pulse_encoder #(.WIDTH(3), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .target(t2), .target_valid(tv2), .target_ready(rdy2),
    .inc(inc2), .dec(dec2), .mirror(mir2), .busy(busy2), .done(done2));

  // Downstream pulse counters sharing clk/rst with the encoders.
  logic [2:0] ds0, ds2;
  always_ff @(posedge clk) begin
    if (rst) begin
      ds0 <= '0;
      ds2 <= '0;
    end else begin
      if (inc0) ds0 <= ds0 + 3'd1; else if (dec0) ds0 <= ds0 - 3'd1;
      if (inc2) ds2 <= ds2 + 3'd1; else if (dec2) ds2 <= ds2 - 3'd1;
    end
  end

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic       done;
    logic       busy;
    logic [2:0] mir;
  } exp_t;

  logic sel = 1'b0;
  exp_t obs;
  logic obs_rdy;
  logic [2:0] obs_ds;
  always_comb begin
    obs     = sel ? {inc2, dec2, done2, busy2, mir2} : {inc0, dec0, done0, busy0, mir0};
    obs_rdy = sel ? rdy2 : rdy0;
    obs_ds  = sel ? ds2 : ds0;
  end

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // Drive one target on instance s and queue the expected outputs for every
  // edge after the accept, up to and including the done edge.
  task automatic drive_target(input logic s, input logic [2:0] t, input logic [2:0] m0,
                              input bit hold);
    int   g, d, n, step;
    bit   up;
    exp_t e;
    g   = s ? 2 : 0;
    sel = s;
    up  = (t > m0);
    d   = up ? int'(t) - int'(m0) : int'(m0) - int'(t);
    @(negedge clk);
    if (s) begin t2 = t; tv2 = 1'b1; end else begin t0 = t; tv0 = 1'b1; end
    @(posedge clk);
    #1;
    if (!hold) begin tv0 = 1'b0; tv2 = 1'b0; end
    n = d * (g + 1);
    for (int j = 1; j <= n + 1; j++) begin
      e = '0;
      if (j <= n) begin
        step   = (j - 1) / (g + 1) + 1;
        e.busy = 1'b1;
        e.inc  = up && ((j - 1) % (g + 1) == 0);
        e.dec  = !up && ((j - 1) % (g + 1) == 0);
        e.mir  = up ? 3'(int'(m0) + step) : 3'(int'(m0) - step);
      end else begin
        e.done = 1'b1;
        e.mir  = t;
      end
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({inc0, dec0, done0, busy0, rdy0, mir0, inc2, dec2, done2, busy2, rdy2, mir2} !== '0) begin
      errs++;
      $display("FAIL reset_state: got u0=%b%b%b%b%b m%0d u2=%b%b%b%b%b m%0d, want all 0",
               inc0, dec0, done0, busy0, rdy0, mir0, inc2, dec2, done2, busy2, rdy2, mir2);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if ({rdy0, rdy2} !== 2'b11) begin
      errs++;
      $display("FAIL reset_release_ready: got %b, want 11", {rdy0, rdy2});
    end
  endtask

  task automatic test_inc();
    exp_t e;
    drive_target(1'b0, 3'd5, 3'd0, 1'b0);
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL inc_seq: got %b, want %b", obs, e);
      end
    end
    vecs++;
    if ({obs_rdy, obs_ds} !== {1'b1, 3'd5}) begin
      errs++;
      $display("FAIL inc_downstream: got rdy=%b ds=%0d, want rdy=1 ds=5", obs_rdy, obs_ds);
    end
  endtask

  task automatic test_dec();
    exp_t e;
    drive_target(1'b0, 3'd2, 3'd5, 1'b0);
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL dec_seq: got %b, want %b", obs, e);
      end
    end
    vecs++;
    if (obs_ds !== 3'd2) begin
      errs++;
      $display("FAIL dec_downstream: got %0d, want 2", obs_ds);
    end
  endtask

  task automatic test_equal();
    exp_t e;
    drive_target(1'b0, 3'd2, 3'd2, 1'b0);
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL equal_seq: got %b, want %b", obs, e);
      end
    end
    @(posedge clk); @(negedge clk);
    vecs++;
    if ({obs_rdy, obs.busy, obs.done, obs.mir} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
      errs++;
      $display("FAIL equal_after: got rdy=%b busy=%b done=%b m=%0d, want 1 0 0 2",
               obs_rdy, obs.busy, obs.done, obs.mir);
    end
  endtask

  // Valid stays high through RUN with a different target; only the first is taken.
  task automatic test_hold_valid();
    exp_t e;
    drive_target(1'b0, 3'd4, 3'd2, 1'b1);
    t0 = 3'd0;
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      if (e.done) tv0 = 1'b0;
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL hold_seq: got %b, want %b", obs, e);
      end
    end
    @(posedge clk); @(negedge clk);
    vecs++;
    if ({obs.busy, obs.mir, obs_ds} !== {1'b0, 3'd4, 3'd4}) begin
      errs++;
      $display("FAIL hold_after: got busy=%b m=%0d ds=%0d, want 0 4 4", obs.busy, obs.mir, obs_ds);
    end
  endtask

  task automatic test_gap();
    exp_t e;
    drive_target(1'b1, 3'd3, 3'd0, 1'b0);
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL gap_seq: got %b, want %b", obs, e);
      end
    end
    vecs++;
    if (obs_ds !== 3'd3) begin
      errs++;
      $display("FAIL gap_downstream: got %0d, want 3", obs_ds);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    drive_target(1'b0, 3'd7, 3'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL midrun_pulse: got %b, want %b", obs, e);
      end
    end
    q.delete();
    rst = 1'b1;
    #1;
    vecs++;
    if (obs_rdy !== 1'b0) begin
      errs++;
      $display("FAIL midrun_ready_in_rst: got %b, want 0", obs_rdy);
    end
    @(posedge clk); @(negedge clk);
    vecs++;
    if ({obs, obs_ds} !== '0) begin
      errs++;
      $display("FAIL midrun_abort: got %b ds=%0d, want all 0", obs, obs_ds);
    end
    rst = 1'b0;
    drive_target(1'b0, 3'd1, 3'd0, 1'b0);
    while (q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL midrun_restart: got %b, want %b", obs, e);
      end
    end
    vecs++;
    if (obs_ds !== 3'd1) begin
      errs++;
      $display("FAIL midrun_downstream: got %0d, want 1", obs_ds);
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_dec();
    test_equal();
    test_hold_valid();
    test_gap();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
